// File: rtl/sram_responder.sv
// sram_responder: on-chip stand-in for the SLC-3 asynchronous SRAM port.
// After reset it zero-fills the whole array, then serves byte-laned bus
// writes, pipelined reads on a bidirectional bus, and word preloads on a
// valid/ready port. The bus has priority over the preload port.
module sram_responder #(
    parameter int DEPTH_W  = 10,
    parameter int READ_LAT = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               CE,
    input  logic               UB,
    input  logic               LB,
    input  logic               OE,
    input  logic               WE,
    input  logic [19:0]        ADDR,
    inout  wire  [15:0]        Data,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [DEPTH_W-1:0] ld_addr,
    input  logic [15:0]        ld_data,
    output logic               init_done,
    output logic [15:0]        wr_count
);

    localparam int WORDS = 2 ** DEPTH_W;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                     state, state_nxt;
    logic [DEPTH_W-1:0]         ptr;
    logic [15:0]                mem [WORDS];
    logic [READ_LAT-1:0][15:0]  rd_pipe;
    logic [15:0]                rd_out;
    logic [DEPTH_W-1:0]         idx;
    logic                       ready, bus_wr, ld_fire, drv_hi, drv_lo;
    logic                       unused_addr_hi;

    // Upper address bits alias onto the implemented words.
    assign idx            = ADDR[DEPTH_W-1:0];
    assign unused_addr_hi = ^ADDR[19:DEPTH_W];

    assign ready     = (state == S_READY);
    assign init_done = ready;
    assign bus_wr    = ready & ~CE & ~WE;
    // A bus write in the same cycle stalls the preload; the source holds it.
    assign ld_ready  = ready & ~(~CE & ~WE);
    assign ld_fire   = ld_valid & ld_ready;

    // State register and clear pointer; reset at any point restarts the clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) ptr <= ptr + 1'b1;
        end
    end

    // Leave CLEAR on the edge that zeroes the last word; READY is terminal.
    always_comb begin
        state_nxt = state;
        if (state == S_CLEAR && (&ptr)) state_nxt = S_READY;
    end

    // Single write port: clear, then bus write (per byte lane), then preload.
    always_ff @(posedge Clk) begin
        if (state == S_CLEAR) begin
            mem[ptr] <= '0;
        end else if (bus_wr) begin
            if (!UB) mem[idx][15:8] <= Data[15:8];
            if (!LB) mem[idx][7:0]  <= Data[7:0];
        end else if (ld_fire) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Read pipeline; old word is returned on read-during-write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_pipe <= '0;
        end else if (ready) begin
            rd_pipe[0] <= mem[idx];
            for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // Committed bus writes, saturating; lane-less writes still count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                              wr_count <= '0;
        else if (bus_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end

    // Lane drivers are purely combinational; WE low always releases the bus.
    assign rd_out = rd_pipe[READ_LAT-1];
    assign drv_hi = ready & ~CE & ~OE & WE & ~UB;
    assign drv_lo = ready & ~CE & ~OE & WE & ~LB;
    assign Data[15:8] = drv_hi ? rd_out[15:8] : 8'bz;
    assign Data[7:0]  = drv_lo ? rd_out[7:0]  : 8'bz;

endmodule
